// File: rtl/kpn_fixed_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kpn_fixed_pkg
// Brief    : shared fixed-point word layout, scheduler states and digit check
// Revision : 1.0
//------------------------------------------------------------------------------
package kpn_fixed_pkg;

  localparam int INT_W  = 12;
  localparam int FRAC_W = 4;
  localparam int WORD_W = INT_W + FRAC_W;
  localparam logic [FRAC_W-1:0] FRAC_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } sched_state_t;

  // The low nibble holds one decimal digit, so 10..15 are malformed operands.
  function automatic logic frac_valid(input logic [WORD_W-1:0] word);
    return (word[FRAC_W-1:0] <= FRAC_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : combinational round-robin pick starting one past the last winner
// Revision : 1.0
//------------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!grant_valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
        grant_valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : adder_scheduler
// Brief    : time-shares one registered fixed-point adder among NUM_REQ channels
// Revision : 1.0
//------------------------------------------------------------------------------
module adder_scheduler
  import kpn_fixed_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDER_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [WORD_W*NUM_REQ-1:0] req_entry_1,
  input  logic [WORD_W*NUM_REQ-1:0] req_entry_2,
  output logic [WORD_W-1:0]         adder_entry_1,
  output logic [WORD_W-1:0]         adder_entry_2,
  input  logic [WORD_W-1:0]         adder_output_1,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [WORD_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_W = $clog2(ADDER_LATENCY + 1);

  sched_state_t         r_state;
  sched_state_t         w_next;
  logic [c_IDX_W-1:0]   r_last;
  logic [c_IDX_W-1:0]   r_gnt_idx;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]    r_adder_e1;
  logic [WORD_W-1:0]    r_adder_e2;
  logic [WORD_W-1:0]    r_rsp_data;
  logic                 r_rsp_err;

  logic [NUM_REQ-1:0]   w_arb_grant;
  logic [c_IDX_W-1:0]   w_arb_idx;
  logic                 w_arb_valid;
  logic [WORD_W-1:0]    w_op1;
  logic [WORD_W-1:0]    w_op2;
  logic                 w_err;
  logic                 w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_arb (
    .req         (req_valid),
    .last        (r_last),
    .grant       (w_arb_grant),
    .grant_idx   (w_arb_idx),
    .grant_valid (w_arb_valid)
  );

  always_comb begin
    w_op1 = req_entry_1[WORD_W-1:0];
    w_op2 = req_entry_2[WORD_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == c_IDX_W'(i)) begin
        w_op1 = req_entry_1[i*WORD_W +: WORD_W];
        w_op2 = req_entry_2[i*WORD_W +: WORD_W];
      end
    end
  end

  assign w_err    = !(frac_valid(w_op1) && frac_valid(w_op2));
  assign w_accept = (r_state == IDLE) && w_arb_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_next = w_err ? RESPOND : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == c_CNT_W'(1)) w_next = RESPOND;
      RESPOND: if (rsp_ready[r_gnt_idx]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grants are gated by reset so nothing leaks out while rst_n is held low.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (r_state != IDLE);
    if ((r_state == IDLE) && rst_n) req_ready = w_arb_grant;
    if (r_state == RESPOND) rsp_valid[r_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= c_IDX_W'(NUM_REQ - 1);
      r_gnt_idx  <= '0;
      r_cnt      <= '0;
      r_adder_e1 <= '0;
      r_adder_e2 <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last    <= w_arb_idx;
        r_gnt_idx <= w_arb_idx;
        if (w_err) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_adder_e1 <= w_op1;
          r_adder_e2 <= w_op2;
        end
      end
      if (r_state == ISSUE) r_cnt <= c_CNT_W'(ADDER_LATENCY);
      if (r_state == WAIT) begin
        if (r_cnt == c_CNT_W'(1)) begin
          r_rsp_data <= adder_output_1;
          r_rsp_err  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
      end
    end
  end

  assign adder_entry_1 = r_adder_e1;
  assign adder_entry_2 = r_adder_e2;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_adder_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_adder_scheduler
// Brief    : randomized scoreboard bench with a decimal fixed-point reference
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_adder_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [16*NUM_REQ-1:0] req_entry_1;
  logic [16*NUM_REQ-1:0] req_entry_2;
  logic [15:0]          adder_entry_1;
  logic [15:0]          adder_entry_2;
  logic [15:0]          adder_out;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;

  logic [15:0] op1 [NUM_REQ];
  logic [15:0] op2 [NUM_REQ];

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
    longint      due;
  } job_t;

  job_t              sb[$];
  int                grant_log[$];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                n_accepts = 0;
  int                model_last = NUM_REQ - 1;
  longint            cyc = 0;
  logic [NUM_REQ-1:0] acc_now = '0;
  logic [15:0]       exp_a1 = '0;
  logic [15:0]       exp_a2 = '0;
  int                refill_mode = 0;
  int                rdy_mode = 0;

  always #5 clk = ~clk;

  adder_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .ADDER_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_entry_1    (req_entry_1),
    .req_entry_2    (req_entry_2),
    .adder_entry_1  (adder_entry_1),
    .adder_entry_2  (adder_entry_2),
    .adder_output_1 (adder_out),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .busy           (busy)
  );

  always_comb begin
    req_entry_1 = '0;
    req_entry_2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_entry_1[16*i +: 16] = op1[i];
      req_entry_2[16*i +: 16] = op2[i];
    end
  end

  // Shared adder stand-in: digit-wise add with decimal carry, one register stage.
  function automatic logic [15:0] hw_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  f;
    logic [11:0] n;
    f = 5'(a[3:0]) + 5'(b[3:0]);
    n = a[15:4] + b[15:4];
    if (f > 5'd9) begin
      f = f - 5'd10;
      n = n + 12'd1;
    end
    return {n, f[3:0]};
  endfunction

  always @(posedge clk) adder_out <= hw_add(adder_entry_1, adder_entry_2);

  // Reference: treat each word as a count of tenths, wrap at 4096 whole units.
  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    int va, vb, s;
    va = int'(a[15:4]) * 10 + int'(a[3:0]);
    vb = int'(b[15:4]) * 10 + int'(b[3:0]);
    s  = (va + vb) % 40960;
    return {12'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [NUM_REQ-1:0] rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (v[i]) return NUM_REQ'(1) << i;
    end
    return '0;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w[15:4] = 12'($urandom);
    if ($urandom_range(0, 9) == 0) w[15:4] = 12'hFFF;
    if ($urandom_range(0, 7) == 0) w[3:0] = 4'($urandom_range(10, 15));
    else                           w[3:0] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor / scoreboard: every expectation comes from the model state here.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      model_last = NUM_REQ - 1;
      exp_a1     = '0;
      exp_a2     = '0;
      acc_now    = '0;
    end else begin
      logic [NUM_REQ-1:0] exp_grant;
      logic [NUM_REQ-1:0] exp_rv;
      logic               exp_busy;
      cyc++;
      exp_busy = (sb.size() != 0);
      check_eq("busy", 32'(busy), 32'(exp_busy));
      exp_grant = exp_busy ? '0 : rr_pick(model_last, req_valid);
      check_eq("req_ready", 32'(req_ready), 32'(exp_grant));
      check_eq("adder_entry_1", 32'(adder_entry_1), 32'(exp_a1));
      check_eq("adder_entry_2", 32'(adder_entry_2), 32'(exp_a2));
      exp_rv = '0;
      if (sb.size() != 0 && cyc >= sb[0].due) exp_rv = NUM_REQ'(1) << sb[0].idx;
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
        check_eq("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        check_eq("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        if (rsp_ready[sb[0].idx]) void'(sb.pop_front());
      end
      acc_now = exp_grant;
      if (exp_grant != '0) begin
        job_t j;
        for (int i = 0; i < NUM_REQ; i++) if (exp_grant[i]) j.idx = i;
        j.err  = (op1[j.idx][3:0] > 4'd9) || (op2[j.idx][3:0] > 4'd9);
        j.data = j.err ? 16'h0000 : ref_sum(op1[j.idx], op2[j.idx]);
        j.due  = cyc + (j.err ? 1 : 2 + LAT);
        if (!j.err) begin
          exp_a1 = op1[j.idx];
          exp_a2 = op2[j.idx];
        end
        sb.push_back(j);
        model_last = j.idx;
        n_accepts++;
        grant_log.push_back(j.idx);
      end
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_now[i]) begin
        if (refill_mode == 2 || (refill_mode == 1 && $urandom_range(0, 1) == 1)) begin
          op1[i] = rand_word();
          op2[i] = rand_word();
        end else begin
          req_valid[i] = 1'b0;
        end
      end else if (refill_mode == 1 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        op1[i]       = rand_word();
        op2[i]       = rand_word();
        req_valid[i] = 1'b1;
      end
    end
    case (rdy_mode)
      0:       rsp_ready = '1;
      1:       rsp_ready = NUM_REQ'($urandom);
      default: rsp_ready = '0;
    endcase
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cycles && !done; n++) begin
      step_cycle();
      if (req_valid == '0 && sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_adder_entry_1", 32'(adder_entry_1), 32'd0);
    check_eq("rst_adder_entry_2", 32'(adder_entry_2), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b);
    op1[i]       = a;
    op2[i]       = b;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    int n0;
    int base;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      op1[i] = '0;
      op2[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Single job with decimal carry, then a plain one on requester 2.
    issue(0, 16'h0125, 16'h0037);
    wait_drain(50);
    issue(2, 16'h00A3, 16'h0014);
    wait_drain(50);

    // Malformed digit: error response, adder operands untouched.
    issue(1, 16'h001C, 16'h0003);
    wait_drain(50);

    // Backpressure on requester 0 with others waiting.
    rdy_mode = 2;
    issue(0, 16'h0459, 16'h0101);
    step_cycle();
    issue(1, 16'h0010, 16'h0020);
    issue(3, 16'h0FF5, 16'h0006);
    for (int n = 0; n < 20 && rsp_valid == '0; n++) step_cycle();
    repeat (5) step_cycle();
    rdy_mode = 0;
    wait_drain(100);

    // Reset while the job is in WAIT.
    issue(3, 16'h0042, 16'h0017);
    n0 = n_accepts;
    for (int n = 0; n < 20 && n_accepts == n0; n++) step_cycle();
    if (n_accepts == n0) check_eq("accept_timeout", 32'd1, 32'd0);
    step_cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < NUM_REQ; i++) issue(i, rand_word(), rand_word());
    repeat (3) step_cycle();
    check_eq("rst_hold_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Fairness with everyone asking continuously.
    refill_mode = 2;
    base = grant_log.size();
    for (int n = 0; n < 100 && grant_log.size() < base + 6; n++) step_cycle();
    if (grant_log.size() < base + 6) check_eq("fair_timeout", 32'd1, 32'd0);
    else for (int k = 0; k < 6; k++) check_eq("fair_order", 32'(grant_log[base + k]), 32'(exp_order[k]));
    refill_mode = 0;
    wait_drain(200);

    // Random traffic with random response backpressure.
    refill_mode = 1;
    rdy_mode    = 1;
    n0 = n_accepts;
    for (int n = 0; n < 20000 && n_accepts < n0 + 200; n++) step_cycle();
    if (n_accepts < n0 + 200) check_eq("random_timeout", 32'd1, 32'd0);
    refill_mode = 0;
    wait_drain(2000);

    repeat (2) step_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
